sig_sink: RTL
=============

// Module: sig_sink
// PURPOSE
//   Memory-mapped signature/halt device on the data-memory write path. Captures
//   stores to SIG_ADDR into a FIFO, drains them over a valid/ready stream to a
//   host-side consumer (UART/dump logic), and raises halt/done on a store to
//   HALT_ADDR. Sits beside Dmem, sampling the same address/data/strobe as Dmem.
// PARAMETERS
//   SIG_ADDR   32'h00000F00  store address captured as signature word
//   HALT_ADDR  32'hCAFEBEEF  store address that requests halt
//   DEPTH      16            FIFO entries, power of two, >= 2
//   AW         $clog2(DEPTH) pointer width (derived, not overridden)
// PORTS
//   clk        in   1     single clock, all logic on posedge
//   rst        in   1     synchronous, active-high reset
//   addr       in   32    data-memory address of current access
//   wdata      in   32    store data
//   wr         in   1     active-low write strobe (0 = store this cycle), same as Dmem
//   sig_valid  out  1     FIFO head valid
//   sig_data   out  32    FIFO head word (first-word fall-through)
//   sig_ready  in   1     consumer accepts head when sig_valid & sig_ready
//   sig_count  out  AW+1  words currently held, 0..DEPTH
//   halt       out  1     halt requested; core must stop issuing stores
//   done       out  1     halt requested and FIFO fully drained
//   overflow   out  1     sticky: a signature store was dropped (FIFO full)
// BEHAVIOUR
//   - Reset: all outputs 0, pointers 0, state RUN; sig_data 0 while empty.
//   - push = (state==RUN) & ~wr & (addr==SIG_ADDR); full address compare, no masking.
//   - pop  = sig_valid & sig_ready.
//   - Latency: push in cycle N -> word visible on sig_data/sig_valid in N+1.
//   - FIFO order strict; sig_data stable while sig_valid & ~sig_ready.
//   - Full & push & ~pop: word dropped, overflow<=1 (sticky until rst), count unchanged.
//   - Full & push & pop: both occur, count stays DEPTH, no overflow.
//   - Empty & push & pop: pop ignored (sig_valid was 0); count -> 1.
//   - Pointers wrap modulo DEPTH; count tracks separately (AW+1 bits).
//   - State machine:
//       RUN   : store to HALT_ADDR (~wr) -> DRAIN; halt<=1 next cycle.
//               Same-cycle store to both not possible (one addr); SIG push in
//               the cycle before halt store is kept.
//       DRAIN : pushes disabled, pops continue; count==0 -> DONE (done<=1 next
//               cycle; if already empty at entry, DONE one cycle after DRAIN).
//       DONE  : terminal; halt=1, done=1; all stores ignored; only rst exits.
//   - Stores to HALT_ADDR in DRAIN/DONE ignored. Loads (wr=1) never affect state.
//   - Stores to any other address ignored (Dmem handles them).
//   - rst mid-operation: FIFO contents discarded, flags cleared, state RUN
//     on the cycle following rst high; rst has priority over push/pop.
// TESTING
//   1. Store 0x11111111,0x22222222,0x33333333 to 0xF00, sig_ready=1 ->
//      sig_data same order, each 1 cycle after store; count returns 0.
//   2. sig_ready=0, DEPTH+1 stores to 0xF00 -> count=DEPTH, overflow=1,
//      drained words = first DEPTH values; extra word absent.
//   3. 4 words queued, sig_ready=0, store to 0xCAFEBEEF -> halt=1, done=0;
//      later store to 0xF00 ignored; raise sig_ready -> 4 words out, then done=1.
//   4. Empty FIFO, store to 0xCAFEBEEF -> halt=1 next cycle, done=1 one cycle later.
//   5. Full FIFO, push and pop same cycle -> count stays DEPTH, overflow=0,
//      pointer wrap verified over 3*DEPTH words with no loss or reorder.
//   6. Assert rst in DRAIN with 3 words queued -> next cycle sig_valid=0,
//      halt=0, done=0, overflow=0, count=0; new 0xF00 store accepted.

Source files
------------

// File: rtl/sig_sink.sv
// sig_sink: signature/halt device sitting beside Dmem on the store path.
// Stores to SIG_ADDR are queued in a first-word fall-through FIFO and
// streamed out over valid/ready. A store to HALT_ADDR stops further
// capture, lets the FIFO drain, then reports done.
module sig_sink #(
   parameter logic [31:0] SIG_ADDR  = 32'h00000F00,
   parameter logic [31:0] HALT_ADDR = 32'hCAFEBEEF,
   parameter int          DEPTH     = 16,
   localparam int         AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   input  logic          wr,
   output logic          sig_valid,
   output logic [31:0]   sig_data,
   input  logic          sig_ready,
   output logic [AW:0]   sig_count,
   output logic          halt,
   output logic          done,
   output logic          overflow
);

   // Controller states.
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_nxt;

   logic store;
   logic sig_hit;
   logic halt_hit;
   logic push;
   logic pop;
   logic full;
   logic wr_en;
   logic drop;

   // Decode the shared Dmem strobe: full 32-bit compare, loads never match.
   assign store    = ~wr;
   assign sig_hit  = store & (addr == SIG_ADDR);
   assign halt_hit = store & (addr == HALT_ADDR);

   // Capture only while running; a pop is only real when head is valid.
   assign push  = (state == ST_RUN) & sig_hit;
   assign pop   = sig_valid & sig_ready;
   assign full  = (count == CNT_FULL);

   // A push into a full FIFO still lands if the head leaves the same cycle.
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   // Next occupancy: push and pop together leave the count unchanged.
   always_comb begin
      count_nxt = count;
      if (wr_en && !pop)
         count_nxt = count + CNT_ONE;
      else if (!wr_en && pop)
         count_nxt = count - CNT_ONE;
   end

   // Halt sequencing: RUN -> DRAIN on halt store, DRAIN -> DONE once empty.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (halt_hit)      state_nxt = ST_DRAIN;
         ST_DRAIN: if (count == '0)   state_nxt = ST_DONE;
         ST_DONE:                     state_nxt = ST_DONE;
         default:                     state_nxt = ST_RUN;
      endcase
   end

   // State register; reset wins over any store in the same cycle.
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_nxt;
         if (drop)
            overflow <= 1'b1;
      end
   end

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (!rst && wr_en)
         mem[wr_ptr] <= wdata;
   end

   // Head presentation: zero while empty so the bus is quiet.
   assign sig_valid = (count != '0);
   assign sig_data  = sig_valid ? mem[rd_ptr] : 32'h0;
   assign sig_count = count;

   // halt asserts the cycle after the halt store; done once drained.
   assign halt = (state != ST_RUN);
   assign done = (state == ST_DONE);

endmodule
